// File: rtl/enemy_fleet_ctrl.sv
// N-channel enemy controller: each channel waits a spawn delay, walks x toward X_END
// at its own speed, and can be killed (optionally respawning). All timing is tick-gated.
module enemy_fleet_ctrl #(
    parameter int NUM_ENEMIES   = 3,
    parameter int OUT_WIDTH     = 8,
    parameter int X_START       = 0,
    parameter int X_END         = 240,
    parameter int STEP          = 1,
    parameter int TIMER_WIDTH   = 24,
    parameter int SPAWN_BASE    = 1000,
    parameter int SPAWN_STRIDE  = 200,
    parameter int SPEED_BASE    = 1000,
    parameter int SPEED_STRIDE  = 200,
    parameter int RESPAWN       = 0,
    parameter int RESPAWN_DELAY = 500
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic [NUM_ENEMIES-1:0]           kill,
    output logic [NUM_ENEMIES-1:0]           spawn,
    output logic [NUM_ENEMIES-1:0]           active,
    output logic [NUM_ENEMIES*OUT_WIDTH-1:0] xpos,
    output logic [NUM_ENEMIES-1:0]           arrived,
    output logic                             all_arrived,
    output logic [7:0]                       kill_count
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_MOVE,
        S_ARRIVED,
        S_DEAD
    } state_t;

    localparam logic [OUT_WIDTH-1:0]   X_START_O = OUT_WIDTH'(X_START);
    localparam logic [OUT_WIDTH-1:0]   X_END_O   = OUT_WIDTH'(X_END);
    localparam logic [OUT_WIDTH:0]     X_END_W   = (OUT_WIDTH+1)'(X_END);
    localparam logic [OUT_WIDTH:0]     STEP_W    = (OUT_WIDTH+1)'(STEP);
    localparam logic [TIMER_WIDTH-1:0] RESP_LAST = TIMER_WIDTH'(RESPAWN_DELAY - 1);

    logic [NUM_ENEMIES-1:0] kill_valid;

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_ch
        localparam logic [TIMER_WIDTH-1:0] DELAY_LAST  = TIMER_WIDTH'(SPAWN_BASE + i*SPAWN_STRIDE - 1);
        localparam logic [TIMER_WIDTH-1:0] PERIOD_LAST = TIMER_WIDTH'(SPEED_BASE + i*SPEED_STRIDE - 1);

        state_t                 state;
        logic [TIMER_WIDTH-1:0] timer;
        logic [OUT_WIDTH-1:0]   x_q;
        logic                   spawn_q;
        logic                   active_q;
        logic                   arrived_q;
        logic [OUT_WIDTH:0]     x_sum;
        logic [OUT_WIDTH-1:0]   x_next;

        // One extra bit on the sum so a step past X_END clamps instead of wrapping.
        always_comb begin
            // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
            x_sum  = {1'b0, x_q} + STEP_W;
            x_next = (x_sum >= X_END_W) ? X_END_O : x_sum[OUT_WIDTH-1:0];
        end

        assign kill_valid[i] = kill[i] && (state == S_MOVE);

        // One timer is shared by WAIT, MOVE and DEAD since a channel is only ever in one of them.
        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= S_WAIT;
                timer     <= '0;
                x_q       <= X_START_O;
                spawn_q   <= 1'b0;
                active_q  <= 1'b0;
                arrived_q <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments keep every register updating from pre-edge values.
                spawn_q <= 1'b0;
                case (state)
                    S_WAIT: begin
                        if (tick) begin
                            if (timer == DELAY_LAST) begin
                                state    <= S_MOVE;
                                timer    <= '0;
                                spawn_q  <= 1'b1;
                                active_q <= 1'b1;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    S_MOVE: begin
                        if (kill[i]) begin
                            state    <= S_DEAD;
                            timer    <= '0;
                            active_q <= 1'b0;
                            x_q      <= X_START_O;
                        end else if (tick) begin
                            if (timer == PERIOD_LAST) begin
                                timer <= '0;
                                x_q   <= x_next;
                                if (x_next == X_END_O) begin
                                    state     <= S_ARRIVED;
                                    active_q  <= 1'b0;
                                    arrived_q <= 1'b1;
                                end
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    S_DEAD: begin
                        if (RESPAWN != 0 && tick) begin
                            if (timer == RESP_LAST) begin
                                state    <= S_MOVE;
                                timer    <= '0;
                                x_q      <= X_START_O;
                                spawn_q  <= 1'b1;
                                active_q <= 1'b1;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    S_ARRIVED: ;
                    default:   state <= S_WAIT;
                endcase
            end
        end

        assign spawn[i]                       = spawn_q;
        assign active[i]                      = active_q;
        assign arrived[i]                     = arrived_q;
        assign xpos[i*OUT_WIDTH +: OUT_WIDTH] = x_q;
    end

    logic [8:0] kc_sum;

    always_comb begin
        kc_sum = {1'b0, kill_count};
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            kc_sum = kc_sum + 9'(kill_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_count  <= '0;
            all_arrived <= 1'b0;
        end else begin
            kill_count  <= kc_sum[8] ? 8'hFF : kc_sum[7:0];
            all_arrived <= &arrived;
        end
    end

endmodule
